// File: rtl/base_acredit_pkg.sv
// Shared helpers for the credit source arbiter: credit-counter and round-robin pointer widths.
// Pure compile-time constants; no logic of its own.
package base_acredit_pkg;

    // Counter must represent every value from 0 up to and including the credit count.
    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    // Pointer width for a round-robin over 'ways' requesters; at least one bit.
    function automatic int ptr_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int RR_WAYS_DEFAULT = 2;
    localparam int RR_PTR_W        = ptr_w(RR_WAYS_DEFAULT);

endpackage

// File: rtl/base_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping at 'ways'.
// Latency: grant is combinational from req/en; pointer moves one cycle after an advance.
// Backpressure: en low suppresses every grant; the pointer only moves on advance.
module base_rr_arb
    import base_acredit_pkg::*;
#(
    parameter int ways = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ways-1:0]        req,
    input  logic                   en,
    output logic [ways-1:0]        gnt,
    output logic [ptr_w(ways)-1:0] gnt_idx,
    input  logic                   advance
);

    localparam int pw = ptr_w(ways);

    logic [pw-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int o = 0; o < ways; o++) begin
            // Wrap explicitly at 'ways' so non-power-of-two sizes never index past the end.
            idx = int'(ptr) + o;
            if (idx >= ways) idx = idx - ways;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = pw'(idx);
            end
        end
        if (en && found) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            if (gnt_idx == pw'(ways - 1)) ptr <= '0;
            else                          ptr <= gnt_idx + pw'(1);
        end
    end

endmodule

// File: rtl/base_acredit_src_arb.sv
// Credit-based source arbiter sharing one credit link between 'ways' requesters; optional checker via BASE_ACREDIT_SRC_ARB_CHK_EN.
// Latency: one cycle from a granted request to o_v/o_d; a credit return is usable the cycle after it arrives.
// Backpressure: no grant while the credit count is zero; the link itself is never stalled.
module base_acredit_src_arb
    import base_acredit_pkg::*;
#(
    parameter int ways        = 2,
    parameter int credits     = 4,
    parameter int log_credits = credit_w(credits),
    parameter int width       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways-1:0]       i_v,
    output logic [ways-1:0]       i_r,
    input  logic [ways*width-1:0] i_d,
    output logic                  o_v,
    output logic [width-1:0]      o_d,
    input  logic                  o_c,
    output logic                  o_err
);

    localparam int pw = ptr_w(ways);
    localparam logic [log_credits-1:0] cnt_max = log_credits'(credits);

    logic [log_credits-1:0] cnt;
    logic                   avail;
    logic                   take;
    logic                   give;
    logic [pw-1:0]          gnt_idx;

    assign avail = (cnt != '0);
    assign give  = o_c;
    assign take  = |(i_v & i_r);

    base_rr_arb #(
        .ways    (ways)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (i_v),
        .en      (avail),
        .gnt     (i_r),
        .gnt_idx (gnt_idx),
        .advance (take)
    );

    // A return at full with no launch is an overflow: saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= cnt_max;
        end else if (take && !give) begin
            cnt <= cnt - log_credits'(1);
        end else if (give && !take && cnt != cnt_max) begin
            cnt <= cnt + log_credits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_v <= 1'b0;
            o_d <= '0;
        end else begin
            o_v <= take;
            if (take) o_d <= i_d[int'(gnt_idx)*width +: width];
        end
    end

`ifdef BASE_ACREDIT_SRC_ARB_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err <= 1'b0;
        end else if (give && !take && cnt == cnt_max) begin
            o_err <= 1'b1;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(i_r));
    a_no_take_empty: assert property (@(posedge clk) disable iff (reset) !(take && !avail));
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_base_acredit_src_arb.sv
// Self-checking bench for base_acredit_src_arb: directed scenarios plus a randomized run against a queue-free credit/pointer model.
module tb_base_acredit_src_arb;

    localparam int WAYS = 3;
    localparam int CR   = 4;
    localparam int W    = 8;
`ifdef BASE_ACREDIT_SRC_ARB_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [WAYS-1:0]   i_v;
    logic [WAYS-1:0]   i_r;
    logic [WAYS*W-1:0] i_d;
    logic              o_v;
    logic [W-1:0]      o_d;
    logic              o_c;
    logic              o_err;

    int checks = 0;
    int passes = 0;

    base_acredit_src_arb #(
        .ways    (WAYS),
        .credits (CR),
        .width   (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .o_v     (o_v),
        .o_d     (o_d),
        .o_c     (o_c),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    // One clock: apply inputs, sample the combinational grant, then the registered outputs after the edge.
    task automatic step(input logic [WAYS-1:0] v, input logic [WAYS*W-1:0] d, input logic c,
                        output logic [WAYS-1:0] r, output logic ov, output logic [W-1:0] od,
                        output logic err);
        i_v = v; i_d = d; o_c = c;
        #1;
        r = i_r;
        @(posedge clk);
        #1;
        ov = o_v; od = o_d; err = o_err;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_v = '0; o_c = 1'b0; i_d = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [WAYS-1:0] r;
        do_reset();
        i_v = 3'b111;
        #1;
        r = i_r;
        checks++;
        if (o_v !== 1'b0) $display("FAIL reset_ov: got %b, required 0", o_v); else passes++;
        checks++;
        if (o_d !== 8'h00) $display("FAIL reset_od: got %h, required 00", o_d); else passes++;
        checks++;
        if (o_err !== 1'b0) $display("FAIL reset_err: got %b, required 0", o_err); else passes++;
        checks++;
        if (r !== 3'b001) $display("FAIL reset_gnt: got %b, required 001", r); else passes++;
        i_v = '0;
    endtask

    // Two requesters held valid with no returns drain the four credits alternately.
    task automatic test_drain();
        logic [WAYS-1:0] r, exp_r [6];
        logic [W-1:0]    od, exp_od [6];
        logic            ov, err, exp_ov [6];
        exp_r  = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000};
        exp_ov = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_od = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h22};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            step(3'b011, 24'h332211, 1'b0, r, ov, od, err);
            checks++;
            if (r !== exp_r[s] || ov !== exp_ov[s] || od !== exp_od[s])
                $display("FAIL drain[%0d]: got r=%b ov=%b od=%h, required r=%b ov=%b od=%h",
                         s, r, ov, od, exp_r[s], exp_ov[s], exp_od[s]);
            else passes++;
        end
    endtask

    // Continues from the empty state left by test_drain (pointer at 2).
    task automatic test_refill();
        logic [WAYS-1:0] r;
        logic [W-1:0]    od;
        logic            ov, err;
        step(3'b011, 24'h332211, 1'b1, r, ov, od, err);
        checks++;
        if (r !== 3'b000 || ov !== 1'b0) $display("FAIL refill_same: got r=%b ov=%b, required r=000 ov=0", r, ov); else passes++;
        step(3'b011, 24'h332211, 1'b0, r, ov, od, err);
        checks++;
        if (r !== 3'b001 || ov !== 1'b1 || od !== 8'h11)
            $display("FAIL refill_next: got r=%b ov=%b od=%h, required r=001 ov=1 od=11", r, ov, od);
        else passes++;
        step(3'b011, 24'h332211, 1'b0, r, ov, od, err);
        checks++;
        if (r !== 3'b000 || ov !== 1'b0) $display("FAIL refill_after: got r=%b ov=%b, required r=000 ov=0", r, ov); else passes++;
    endtask

    task automatic test_stream();
        logic [WAYS-1:0] r;
        logic [W-1:0]    od, d;
        logic            ov, err;
        do_reset();
        step(3'b001, 24'h0000aa, 1'b0, r, ov, od, err);
        for (int s = 0; s < 10; s++) begin
            d = W'($urandom);
            step(3'b001, {16'h0, d}, 1'b1, r, ov, od, err);
            checks++;
            if (r !== 3'b001 || ov !== 1'b1 || od !== d)
                $display("FAIL stream[%0d]: got r=%b ov=%b od=%h, required r=001 ov=1 od=%h", s, r, ov, od, d);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        logic [WAYS-1:0] r, exp_r [3], v [3];
        logic [W-1:0]    od;
        logic            ov, err;
        v     = '{3'b100, 3'b101, 3'b101};
        exp_r = '{3'b100, 3'b001, 3'b100};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            step(v[s], 24'hc0b0a0, 1'b0, r, ov, od, err);
            checks++;
            if (r !== exp_r[s]) $display("FAIL wrap[%0d]: got r=%b, required r=%b", s, r, exp_r[s]); else passes++;
        end
    endtask

    task automatic test_overflow();
        logic [WAYS-1:0] r;
        logic [W-1:0]    od;
        logic            ov, err;
        int              grants;
        do_reset();
        step(3'b000, 24'h0, 1'b1, r, ov, od, err);
        checks++;
        if (err !== EXP_ERR) $display("FAIL ovf_err: got %b, required %b", err, EXP_ERR); else passes++;
        step(3'b000, 24'h0, 1'b0, r, ov, od, err);
        checks++;
        if (err !== EXP_ERR) $display("FAIL ovf_sticky: got %b, required %b", err, EXP_ERR); else passes++;
        grants = 0;
        for (int s = 0; s < 6; s++) begin
            step(3'b001, 24'h0, 1'b0, r, ov, od, err);
            if (r == 3'b001) grants++;
        end
        checks++;
        if (grants != CR) $display("FAIL ovf_saturate: got %0d grants, required %0d", grants, CR); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [WAYS-1:0] r;
        logic [W-1:0]    od;
        logic            ov, err;
        int              grants;
        do_reset();
        step(3'b000, 24'h0, 1'b1, r, ov, od, err);
        for (int s = 0; s < 3; s++) step(3'b010, 24'h005500, 1'b0, r, ov, od, err);
        checks++;
        if (ov !== 1'b1) $display("FAIL mid_pre_ov: got %b, required 1", ov); else passes++;
        reset = 1'b1; i_v = 3'b010;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (o_v !== 1'b0 || o_err !== 1'b0)
            $display("FAIL mid_reset: got ov=%b err=%b, required ov=0 err=0", o_v, o_err);
        else passes++;
        step(3'b111, 24'h0, 1'b0, r, ov, od, err);
        checks++;
        if (r !== 3'b001) $display("FAIL mid_ptr: got r=%b, required 001", r); else passes++;
        grants = 1;
        for (int s = 0; s < 5; s++) begin
            step(3'b100, 24'h0, 1'b0, r, ov, od, err);
            if (r == 3'b100) grants++;
        end
        checks++;
        if (grants != CR) $display("FAIL mid_credits: got %0d grants, required %0d", grants, CR); else passes++;
    endtask

    // Random traffic against a model tracking credits held, next-priority index and last launched beat.
    task automatic test_random();
        logic [WAYS-1:0]   r, v, exp_r;
        logic [WAYS*W-1:0] d;
        logic [W-1:0]      od, exp_od;
        logic              ov, err, c, exp_err;
        int                held, next, win;
        do_reset();
        held = CR; next = 0; exp_od = '0; exp_err = 1'b0;
        for (int s = 0; s < 400; s++) begin
            v = WAYS'($urandom_range(0, 7));
            d = WAYS*W'($urandom);
            c = (s % 37 == 36) ? 1'b1 : ((held < CR) && ($urandom_range(0, 2) != 0));
            win = -1;
            if (held > 0)
                for (int o = WAYS - 1; o >= 0; o--)
                    if (v[(next + o) % WAYS]) win = (next + o) % WAYS;
            exp_r = (win >= 0) ? WAYS'(1 << win) : '0;
            step(v, d, c, r, ov, od, err);
            if (win >= 0) begin
                exp_od = d[win*W +: W];
                next   = (win + 1) % WAYS;
            end
            if (c && win < 0 && held == CR) exp_err = EXP_ERR;
            held = held - ((win >= 0) ? 1 : 0) + (c ? 1 : 0);
            if (held > CR) held = CR;
            checks++;
            if (r !== exp_r || ov !== (win >= 0) || od !== exp_od || err !== exp_err)
                $display("FAIL random[%0d]: got r=%b ov=%b od=%h err=%b, required r=%b ov=%b od=%h err=%b",
                         s, r, ov, od, err, exp_r, (win >= 0), exp_od, exp_err);
            else passes++;
        end
    endtask

    initial begin
        reset = 1'b1; i_v = '0; i_d = '0; o_c = 1'b0;
        test_reset();
        test_drain();
        test_refill();
        test_stream();
        test_wrap();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
